mbinit_param_sb_arbiter: RTL and testbench
==========================================

Name: mbinit_param_sb_arbiter

Overview:
- Arbitrates the single sideband transmit path between the two MBINIT.PARAM agents: the Module side, which issues the configuration request, and the ModulePartner side, which issues the configuration response.
- Captures the granted agent's message code and parameter field, then launches one sideband transmission.
- Tracks sideband busy and returns a per-agent completion pulse, replacing the per-agent busy/falling-edge handling.
- Sits between the MBINIT.PARAM FSMs and the sideband TX packetizer.

Parameters:
- DATA_W, 10: width of the parameter field (voltage swing 5 + max data rate 3 + clock mode 1 + phase clock 1).
- TIMEOUT_CYC, 255: cycles to wait for sideband busy to rise after a launch before abandoning it.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  MBINIT.PARAM phase active; deassertion aborts.
- i_mod_valid  in  1  Module agent requests transmit; held until o_mod_done.
- i_mod_msg  in  4  Module message code (e.g. 4'b0001 = configuration req).
- i_mod_data  in  DATA_W  Module parameter field.
- i_ptr_valid  in  1  ModulePartner agent requests transmit; held until o_ptr_done.
- i_ptr_msg  in  4  ModulePartner message code (e.g. 4'b0010 = configuration resp).
- i_ptr_data  in  DATA_W  ModulePartner parameter field.
- i_sb_busy  in  1  sideband TX busy.
- o_sb_valid  out  1  one-cycle launch strobe to the sideband TX.
- o_sb_msg  out  4  captured message code.
- o_sb_data  out  DATA_W  captured parameter field.
- o_sb_src  out  1  owner of the current transfer: 0 = Module, 1 = ModulePartner.
- o_mod_grant  out  1  Module owns the sideband.
- o_ptr_grant  out  1  ModulePartner owns the sideband.
- o_mod_done  out  1  one-cycle pulse: Module transfer complete.
- o_ptr_done  out  1  one-cycle pulse: ModulePartner transfer complete.
- o_timeout  out  1  one-cycle pulse: launch abandoned.

Behaviour:
- Reset: all outputs, o_sb_msg, o_sb_data, the counter and the busy-delay register clear to 0; state IDLE; priority pointer prio = 0 (Module).
- All outputs are registered. i_enable low forces IDLE from any state on the next edge, clearing all outputs, the counter and prio. No done or timeout pulse is issued on an abort.
- busy_q is i_sb_busy delayed one cycle. A falling edge is busy_q=1 and i_sb_busy=0.
- IDLE:
  - i_enable=1 -> ARB.
- ARB:
  - Arbitrates only when i_sb_busy=0 and at least one valid is high.
  - Winner: the single valid agent. If both are valid, the agent selected by prio.
  - Capture the winner's msg and data into o_sb_msg/o_sb_data. Set o_sb_src and the winner's grant. Pulse o_sb_valid for one cycle. Clear the counter. -> SEND.
  - Latency: valid sampled at edge N gives o_sb_valid high in cycle N+1.
  - i_sb_busy=1 holds ARB with no grant.
- SEND:
  - i_sb_busy=1 -> WAIT_LOW.
  - Otherwise the counter increments. When counter == TIMEOUT_CYC: pulse o_timeout, drop the grant, prio <= ~o_sb_src -> GAP.
- WAIT_LOW:
  - Falling edge of busy: pulse the owner's done, drop the grant, prio <= ~o_sb_src -> GAP.
  - Busy staying high waits indefinitely; the sideband owns its own timeout.
- GAP:
  - One cycle; valids are ignored so the requester can drop valid after done. -> ARB.
- Grant, o_sb_src, o_sb_msg and o_sb_data stay stable from the launch until the done or timeout cycle.
- Grant is one-hot or zero; never both.
- Valid dropped by the owner mid-transfer is ignored; the transfer completes normally.
- prio changes only on done or timeout. Alternating service guarantees no starvation.
- Counter saturates at TIMEOUT_CYC and never wraps.

Test Plan:
- rst high, then enable; i_mod_valid=1, msg=4'b0001, data=10'h2A5, busy=0 -> o_sb_valid pulse 1 cycle later with msg 0001, data 2A5, src 0. Then busy high 3 cycles and low -> o_mod_done one cycle after busy falls, followed by one GAP cycle.
- Both valid in the same cycle after reset -> Module served first. After o_mod_done, the ModulePartner launches with msg 4'b0010, 2 cycles after done (GAP, then ARB launch).
- i_ptr_valid=1 while i_sb_busy=1 for 5 cycles -> no grant and no o_sb_valid until 1 cycle after busy is sampled low.
- Launch with busy held 0, TIMEOUT_CYC=4 -> o_timeout pulse 5 cycles after o_sb_valid. Grant drops, no done pulse, prio flips.
- i_enable deasserted during WAIT_LOW -> next cycle: state IDLE, grants 0, no done. A later busy fall produces no pulse.
- Async rst asserted mid-SEND -> outputs are 0 immediately, without a clock edge. After release, the arbiter waits for i_enable.

Source files
------------

// File: rtl/mbinit_param_sb_arbiter_if.sv
// Sideband request/launch bundle between the MBINIT.PARAM agents, the arbiter
// and the sideband TX packetizer.
interface mbinit_param_sb_arbiter_if #(
  parameter int unsigned DATA_W = 10
);
  logic              i_enable;
  logic              i_mod_valid;
  logic [3:0]        i_mod_msg;
  logic [DATA_W-1:0] i_mod_data;
  logic              i_ptr_valid;
  logic [3:0]        i_ptr_msg;
  logic [DATA_W-1:0] i_ptr_data;
  logic              i_sb_busy;
  logic              o_sb_valid;
  logic [3:0]        o_sb_msg;
  logic [DATA_W-1:0] o_sb_data;
  logic              o_sb_src;
  logic              o_mod_grant;
  logic              o_ptr_grant;
  logic              o_mod_done;
  logic              o_ptr_done;
  logic              o_timeout;

  // Arbiter side.
  modport slave (
    input  i_enable, i_mod_valid, i_mod_msg, i_mod_data,
    input  i_ptr_valid, i_ptr_msg, i_ptr_data, i_sb_busy,
    output o_sb_valid, o_sb_msg, o_sb_data, o_sb_src,
    output o_mod_grant, o_ptr_grant, o_mod_done, o_ptr_done, o_timeout
  );

  // Agent / sideband side.
  modport master (
    output i_enable, i_mod_valid, i_mod_msg, i_mod_data,
    output i_ptr_valid, i_ptr_msg, i_ptr_data, i_sb_busy,
    input  o_sb_valid, o_sb_msg, o_sb_data, o_sb_src,
    input  o_mod_grant, o_ptr_grant, o_mod_done, o_ptr_done, o_timeout
  );
endinterface

// File: rtl/mbinit_param_sb_arbiter.sv
// Shares the sideband TX between the MBINIT.PARAM Module and ModulePartner
// agents: arbitrates, launches one message, and reports done or timeout.
module mbinit_param_sb_arbiter #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic                      CLK,
  input logic                      rst,
  mbinit_param_sb_arbiter_if.slave sb
);

  typedef enum logic [2:0] {StIdle, StArb, StSend, StWaitLow, StGap} state_e;

  state_e            state_q, state_d;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              valid_q, valid_d;
  logic [3:0]        msg_q, msg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              mod_grant_q, mod_grant_d;
  logic              ptr_grant_q, ptr_grant_d;
  logic              mod_done_q, mod_done_d;
  logic              ptr_done_q, ptr_done_d;
  logic              tout_q, tout_d;

  logic launch, pick_ptr, cnt_at_max, busy_fall;

  assign launch     = (state_q == StArb) && !sb.i_sb_busy && (sb.i_mod_valid || sb.i_ptr_valid);
  // prio=1 favours the ModulePartner only when both request.
  assign pick_ptr   = sb.i_ptr_valid && (!sb.i_mod_valid || prio_q);
  assign cnt_at_max = (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign busy_fall  = busy_q && !sb.i_sb_busy;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      valid_q     <= 1'b0;
      msg_q       <= '0;
      data_q      <= '0;
      src_q       <= 1'b0;
      mod_grant_q <= 1'b0;
      ptr_grant_q <= 1'b0;
      mod_done_q  <= 1'b0;
      ptr_done_q  <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= sb.i_sb_busy;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      valid_q     <= valid_d;
      msg_q       <= msg_d;
      data_q      <= data_d;
      src_q       <= src_d;
      mod_grant_q <= mod_grant_d;
      ptr_grant_q <= ptr_grant_d;
      mod_done_q  <= mod_done_d;
      ptr_done_q  <= ptr_done_d;
      tout_q      <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!sb.i_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StArb;
        StArb:     if (launch) state_d = StSend;
        StSend: begin
          if (sb.i_sb_busy)    state_d = StWaitLow;
          else if (cnt_at_max) state_d = StGap;
        end
        StWaitLow: if (busy_fall) state_d = StGap;
        StGap:     state_d = StArb;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    valid_d     = 1'b0;
    mod_done_d  = 1'b0;
    ptr_done_d  = 1'b0;
    tout_d      = 1'b0;
    msg_d       = msg_q;
    data_d      = data_q;
    src_d       = src_q;
    mod_grant_d = mod_grant_q;
    ptr_grant_d = ptr_grant_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    if (!sb.i_enable) begin
      msg_d       = '0;
      data_d      = '0;
      src_d       = 1'b0;
      mod_grant_d = 1'b0;
      ptr_grant_d = 1'b0;
      cnt_d       = '0;
      prio_d      = 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (launch) begin
            valid_d     = 1'b1;
            msg_d       = pick_ptr ? sb.i_ptr_msg : sb.i_mod_msg;
            data_d      = pick_ptr ? sb.i_ptr_data : sb.i_mod_data;
            src_d       = pick_ptr;
            mod_grant_d = !pick_ptr;
            ptr_grant_d = pick_ptr;
            cnt_d       = '0;
          end
        end
        StSend: begin
          if (!sb.i_sb_busy) begin
            if (cnt_at_max) begin
              tout_d      = 1'b1;
              mod_grant_d = 1'b0;
              ptr_grant_d = 1'b0;
              prio_d      = !src_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        StWaitLow: begin
          if (busy_fall) begin
            mod_done_d  = !src_q;
            ptr_done_d  = src_q;
            mod_grant_d = 1'b0;
            ptr_grant_d = 1'b0;
            prio_d      = !src_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign sb.o_sb_valid  = valid_q;
  assign sb.o_sb_msg    = msg_q;
  assign sb.o_sb_data   = data_q;
  assign sb.o_sb_src    = src_q;
  assign sb.o_mod_grant = mod_grant_q;
  assign sb.o_ptr_grant = ptr_grant_q;
  assign sb.o_mod_done  = mod_done_q;
  assign sb.o_ptr_done  = ptr_done_q;
  assign sb.o_timeout   = tout_q;

endmodule

// File: tb/tb_mbinit_param_sb_arbiter.sv
// Directed and randomized checks of the sideband arbiter against a
// transaction-level reference model.
module tb_mbinit_param_sb_arbiter;
  localparam int unsigned DW = 10;
  localparam int unsigned TO = 4;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  mbinit_param_sb_arbiter_if #(.DATA_W(DW)) bus ();

  mbinit_param_sb_arbiter #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .CNT_W       (8)
  ) u_dut (
    .CLK (CLK),
    .rst (rst),
    .sb  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the sideband, whether busy was seen, how long
  // the launch has waited, and whether we are in the post-transfer cooldown.
  bit   m_on, m_gap, m_seen, m_prio, m_bprev;
  int   m_owner, m_wait;
  logic e_valid, e_src, e_mg, e_pg, e_md, e_pd, e_to;
  logic [3:0]    e_msg;
  logic [DW-1:0] e_data;

  function automatic void model_reset();
    m_on = 0; m_gap = 0; m_seen = 0; m_prio = 0; m_bprev = 0;
    m_owner = -1; m_wait = 0;
    e_valid = 0; e_src = 0; e_mg = 0; e_pg = 0; e_md = 0; e_pd = 0; e_to = 0;
    e_msg = '0; e_data = '0;
  endfunction

  function automatic void model_release();
    m_prio  = (m_owner == 0);
    m_owner = -1;
    e_mg    = 0;
    e_pg    = 0;
    m_gap   = 1;
  endfunction

  function automatic void model_step();
    bit busy;
    busy = bus.i_sb_busy;
    e_valid = 0; e_md = 0; e_pd = 0; e_to = 0;
    if (!bus.i_enable) begin
      model_reset();
    end else if (!m_on) begin
      m_on = 1;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      if (!busy && (bus.i_mod_valid || bus.i_ptr_valid)) begin
        int w;
        if (bus.i_mod_valid && bus.i_ptr_valid) w = m_prio ? 1 : 0;
        else w = bus.i_mod_valid ? 0 : 1;
        m_owner = w;
        e_valid = 1;
        e_src   = (w == 1);
        e_msg   = (w == 1) ? bus.i_ptr_msg : bus.i_mod_msg;
        e_data  = (w == 1) ? bus.i_ptr_data : bus.i_mod_data;
        e_mg    = (w == 0);
        e_pg    = (w == 1);
        m_wait  = 0;
        m_seen  = 0;
      end
    end else if (!m_seen) begin
      if (busy) m_seen = 1;
      else if (m_wait == int'(TO)) begin
        e_to = 1;
        model_release();
      end else m_wait++;
    end else if (m_bprev && !busy) begin
      if (m_owner == 0) e_md = 1;
      else e_pd = 1;
      model_release();
    end
    m_bprev = busy;
  endfunction

  task automatic compare_all();
    check_eq("sb_valid", bus.o_sb_valid, e_valid);
    check_eq("sb_msg", bus.o_sb_msg, e_msg);
    check_eq("sb_data", bus.o_sb_data, e_data);
    check_eq("sb_src", bus.o_sb_src, e_src);
    check_eq("grants", {bus.o_mod_grant, bus.o_ptr_grant}, {e_mg, e_pg});
    check_eq("grant_excl", bus.o_mod_grant & bus.o_ptr_grant, 0);
    check_eq("dones", {bus.o_mod_done, bus.o_ptr_done}, {e_md, e_pd});
    check_eq("timeout", bus.o_timeout, e_to);
  endtask

  // Inputs are changed right after this returns, so they stay stable across the next posedge.
  task automatic cycle();
    @(negedge CLK);
    model_step();
    compare_all();
  endtask

  task automatic wait_launch(input string tag);
    for (int k = 0; k < 10; k++) begin
      if (bus.o_sb_valid) break;
      cycle();
    end
    check_eq(tag, bus.o_sb_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_enable = 0; bus.i_mod_valid = 0; bus.i_mod_msg = '0; bus.i_mod_data = '0;
    bus.i_ptr_valid = 0; bus.i_ptr_msg = '0; bus.i_ptr_data = '0; bus.i_sb_busy = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all();
    rst = 0;

    // Single Module request, busy 3 cycles.
    bus.i_enable = 1; bus.i_mod_valid = 1; bus.i_mod_msg = 4'b0001; bus.i_mod_data = 10'h2A5;
    cycle();
    cycle();
    check_eq("t1_launch", {bus.o_sb_valid, bus.o_sb_msg, bus.o_sb_data, bus.o_sb_src},
             {1'b1, 4'b0001, 10'h2A5, 1'b0});
    bus.i_sb_busy = 1;
    repeat (3) cycle();
    bus.i_sb_busy = 0;
    cycle();
    check_eq("t1_done", bus.o_mod_done, 1);
    bus.i_mod_valid = 0;
    cycle();

    // Both valid with prio freshly cleared: Module first, then ModulePartner.
    bus.i_enable = 0;
    cycle();
    bus.i_enable = 1;
    cycle();
    bus.i_mod_valid = 1; bus.i_mod_msg = 4'b0001; bus.i_mod_data = 10'h155;
    bus.i_ptr_valid = 1; bus.i_ptr_msg = 4'b0010; bus.i_ptr_data = 10'h0AA;
    cycle();
    check_eq("t2_mod_first", {bus.o_sb_valid, bus.o_sb_src}, {1'b1, 1'b0});
    bus.i_sb_busy = 1; cycle();
    bus.i_sb_busy = 0; cycle();
    check_eq("t2_mod_done", bus.o_mod_done, 1);
    bus.i_mod_valid = 0;
    cycle();
    cycle();
    check_eq("t2_ptr_launch", {bus.o_sb_valid, bus.o_sb_msg, bus.o_sb_src},
             {1'b1, 4'b0010, 1'b1});
    bus.i_sb_busy = 1; cycle();
    bus.i_sb_busy = 0; cycle();
    check_eq("t2_ptr_done", bus.o_ptr_done, 1);
    bus.i_ptr_valid = 0;
    cycle();

    // Request held off by busy, then a launch that times out.
    bus.i_sb_busy = 1; bus.i_ptr_valid = 1;
    repeat (5) cycle();
    check_eq("t3_no_grant", bus.o_ptr_grant, 0);
    bus.i_sb_busy = 0;
    cycle();
    check_eq("t3_launch", bus.o_sb_valid, 1);
    repeat (4) cycle();
    check_eq("t4_no_tout_yet", bus.o_timeout, 0);
    cycle();
    check_eq("t4_tout", {bus.o_timeout, bus.o_ptr_grant, bus.o_ptr_done}, {1'b1, 1'b0, 1'b0});
    bus.i_ptr_valid = 0;

    // Abort during WAIT_LOW.
    bus.i_mod_valid = 1;
    cycle();
    wait_launch("t5_launch_seen");
    bus.i_sb_busy = 1; cycle();
    bus.i_enable = 0; cycle();
    check_eq("t5_abort_grant", {bus.o_mod_grant, bus.o_ptr_grant}, 0);
    bus.i_sb_busy = 0; cycle();
    check_eq("t5_no_done", bus.o_mod_done, 0);

    // Asynchronous reset in the middle of SEND.
    bus.i_enable = 1;
    cycle();
    wait_launch("t6_launch_seen");
    cycle();
    #2 rst = 1;
    #1;
    check_eq("t6_async_clear",
             {bus.o_mod_grant, bus.o_ptr_grant, bus.o_sb_src, bus.o_sb_msg, bus.o_sb_data},
             0);
    model_reset();
    @(negedge CLK);
    rst = 0; bus.i_enable = 0; bus.i_mod_valid = 0;
    repeat (3) cycle();
    bus.i_enable = 1;

    // Randomized agents and sideband.
    for (int i = 0; i < 3000; i++) begin
      if (bus.i_mod_valid && e_md && $urandom_range(0, 1) == 1) bus.i_mod_valid = 0;
      else if (bus.i_mod_valid && e_mg && $urandom_range(0, 15) == 0) bus.i_mod_valid = 0;
      else if (!bus.i_mod_valid && $urandom_range(0, 3) == 0) begin
        bus.i_mod_valid = 1;
        bus.i_mod_msg   = 4'($urandom);
        bus.i_mod_data  = DW'($urandom);
      end
      if (bus.i_ptr_valid && e_pd && $urandom_range(0, 1) == 1) bus.i_ptr_valid = 0;
      else if (bus.i_ptr_valid && e_pg && $urandom_range(0, 15) == 0) bus.i_ptr_valid = 0;
      else if (!bus.i_ptr_valid && $urandom_range(0, 3) == 0) begin
        bus.i_ptr_valid = 1;
        bus.i_ptr_msg   = 4'($urandom);
        bus.i_ptr_data  = DW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) bus.i_sb_busy = ~bus.i_sb_busy;
      if (bus.i_enable && $urandom_range(0, 199) == 0) bus.i_enable = 0;
      else if (!bus.i_enable && $urandom_range(0, 1) == 1) bus.i_enable = 1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
